// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared types and constants for the cacheline <-> 64-bit burst adapter.
package cacheline_burst_adapter_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BURST_BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0]          rv32i_cacheline;
  typedef logic [BURST_WIDTH-1:0]         rv32i_burst;
  typedef logic [ADDR_WIDTH-1:0]          rv32i_addr;
  typedef logic [$clog2(BURST_BEATS)-1:0] beat_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adapter_state_t;

  function automatic rv32i_addr line_align(input rv32i_addr a);
    return {a[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side line port plus memory-side burst port of the adapter.
interface cacheline_burst_adapter_if;
  import cacheline_burst_adapter_pkg::*;

  rv32i_addr      line_addr_i;
  logic           line_read_i;
  logic           line_write_i;
  rv32i_cacheline line_wdata_i;
  rv32i_cacheline line_rdata_o;
  logic           line_resp_o;

  rv32i_addr      mem_addr_o;
  logic           mem_read_o;
  logic           mem_write_o;
  rv32i_burst     mem_wdata_o;
  rv32i_burst     mem_rdata_i;
  logic           mem_resp_i;

  // slave: the adapter itself; master: the cache + memory environment around it
  modport slave (
    input  line_addr_i, line_read_i, line_write_i, line_wdata_i, mem_rdata_i, mem_resp_i,
    output line_rdata_o, line_resp_o, mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
  );

  modport master (
    output line_addr_i, line_read_i, line_write_i, line_wdata_i, mem_rdata_i, mem_resp_i,
    input  line_rdata_o, line_resp_o, mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
  );

endinterface

// File: rtl/cacheline_burst_adapter.sv
// Purpose: splits a 256-bit cacheline fill/writeback into four 64-bit memory beats and reassembles fills.
// Latency: 6 cycles minimum request->line_resp_o (accept, 4 beats, done pulse).
// Backpressure: mem_resp_i low stalls the burst; the cache holds its request until line_resp_o.
module cacheline_burst_adapter
  import cacheline_burst_adapter_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  cacheline_burst_adapter_if.slave bus
);

  adapter_state_t state_q, state_d;
  beat_cnt_t      cnt_q;
  rv32i_addr      addr_q;
  rv32i_cacheline wline_q;
  rv32i_cacheline rline_q;
  logic           last_beat;

  assign last_beat = bus.mem_resp_i && (cnt_q == beat_cnt_t'(BURST_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // writeback wins so a dirty victim leaves before its replacement is fetched
      IDLE: begin
        if (bus.line_write_i)     state_d = WR_BURST;
        else if (bus.line_read_i) state_d = RD_BURST;
      end
      RD_BURST: if (last_beat) state_d = DONE;
      WR_BURST: if (last_beat) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.line_write_i) begin
            addr_q  <= line_align(bus.line_addr_i);
            wline_q <= bus.line_wdata_i;
          end else if (bus.line_read_i) begin
            addr_q  <= line_align(bus.line_addr_i);
          end
        end
        RD_BURST: begin
          if (bus.mem_resp_i) begin
            rline_q[int'(cnt_q) * BURST_WIDTH +: BURST_WIDTH] <= bus.mem_rdata_i;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR_BURST: begin
          if (bus.mem_resp_i) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // mem_* outputs depend only on registered state, never on the line_* inputs
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_read_o   = (state_q == RD_BURST);
  assign bus.mem_write_o  = (state_q == WR_BURST);
  assign bus.mem_wdata_o  = wline_q[int'(cnt_q) * BURST_WIDTH +: BURST_WIDTH];
  assign bus.line_resp_o  = (state_q == DONE);
  assign bus.line_rdata_o = rline_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter: a cache driver, a memory responder and an output monitor.
module tb_cacheline_burst_adapter;

  typedef struct {
    bit               is_wr;
    logic [31:0]      addr;
    logic [3:0][63:0] beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  cacheline_burst_adapter_if ifc();

  cacheline_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [63:0] rd_beats[$];
  int   beat_n = 0;
  int   cyc = 0;
  int   last_beat_cyc = -10;
  int   mode = 0;      // 0: back-to-back, 1: two idle cycles per beat, 2: random stalls
  bit   spurious = 0;
  int   gap_ctr = 0;
  bit   go;

  task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    logic [98:0] v;
    v = {ifc.line_resp_o, ifc.mem_read_o, ifc.mem_write_o, ifc.mem_addr_o, ifc.mem_wdata_o};
    chk(v == '0, {name, "_ctl"}, 256'(v), 256'(0));
    chk(ifc.line_rdata_o == '0, {name, "_rdata"}, ifc.line_rdata_o, 256'(0));
  endtask

  // Memory model: answers beats while a burst is requested, supplying queued fill data in order.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      ifc.mem_resp_i = 1'b0;
      gap_ctr = 0;
    end else if (ifc.mem_read_o || ifc.mem_write_o) begin
      case (mode)
        0:       go = 1'b1;
        1:       go = (gap_ctr == 2);
        default: go = ($urandom_range(0, 2) != 0);
      endcase
      gap_ctr = go ? 0 : gap_ctr + 1;
      ifc.mem_resp_i = go;
      if (go && ifc.mem_read_o)
        ifc.mem_rdata_i = (rd_beats.size() > 0) ? rd_beats.pop_front() : 64'h0;
      else
        ifc.mem_rdata_i = {$urandom, $urandom};
    end else begin
      gap_ctr = 0;
      ifc.mem_resp_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      ifc.mem_rdata_i = {$urandom, $urandom};
    end
  end

  // Monitor: every accepted beat and every completion pulse is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.mem_read_o && ifc.mem_write_o)
        chk(1'b0, "rd_wr_both", 256'(2'b11), 256'(0));
      if (exp_q.size() > 0 && beat_n > 0 && beat_n < 4 && !ifc.line_resp_o)
        chk(ifc.mem_read_o || ifc.mem_write_o, "req_held", 256'(0), 256'(1));
      if ((ifc.mem_read_o || ifc.mem_write_o) && ifc.mem_resp_i) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "beat_unexpected", 256'(ifc.mem_addr_o), 256'(0));
        end else begin
          chk(ifc.mem_addr_o == exp_q[0].addr, "beat_addr", 256'(ifc.mem_addr_o), 256'(exp_q[0].addr));
          chk(ifc.mem_write_o == exp_q[0].is_wr, "beat_kind", 256'(ifc.mem_write_o), 256'(exp_q[0].is_wr));
          if (ifc.mem_write_o && beat_n < 4)
            chk(ifc.mem_wdata_o == exp_q[0].beats[beat_n], "wr_beat",
                256'(ifc.mem_wdata_o), 256'(exp_q[0].beats[beat_n]));
          beat_n++;
        end
        last_beat_cyc = cyc;
      end
      if (ifc.line_resp_o) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "resp_unexpected", 256'(1), 256'(0));
        end else begin
          chk(beat_n == 4, "resp_beats", 256'(beat_n), 256'(4));
          chk(last_beat_cyc == cyc - 1, "resp_after_last", 256'(cyc - last_beat_cyc), 256'(1));
          chk(!ifc.mem_read_o && !ifc.mem_write_o, "resp_req_low",
              256'({ifc.mem_read_o, ifc.mem_write_o}), 256'(0));
          if (!exp_q[0].is_wr)
            chk(ifc.line_rdata_o == 256'(exp_q[0].beats), "rd_line", ifc.line_rdata_o, 256'(exp_q[0].beats));
          void'(exp_q.pop_front());
        end
        beat_n = 0;
      end
      cyc++;
    end
  end

  // Cache driver: holds the request until the completion pulse, then drops it.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0][63:0] data, input int exp_lat);
    exp_t e;
    int   n;
    bit   got;
    e.is_wr = wr;
    e.addr  = addr & ~32'h1F;
    e.beats = data;
    exp_q.push_back(e);
    if (!wr) for (int i = 0; i < 4; i++) rd_beats.push_back(data[i]);
    ifc.line_addr_i  = addr;
    ifc.line_read_i  = rd;
    ifc.line_write_i = wr;
    ifc.line_wdata_i = wr ? 256'(data) : {8{$urandom}};
    n = 0;
    got = 0;
    while (n < 300 && !got) begin
      @(posedge clk);
      #1;
      n++;
      ifc.line_wdata_i = {8{$urandom}};
      if (ifc.line_resp_o) got = 1;
    end
    chk(got, "resp_timeout", 256'(n), 256'(0));
    if (got && exp_lat > 0) chk(n == exp_lat, "latency", 256'(n + 1), 256'(exp_lat + 1));
    @(posedge clk);
    #1;
    ifc.line_read_i  = 1'b0;
    ifc.line_write_i = 1'b0;
    chk(!ifc.line_resp_o, "resp_one_cycle", 256'(ifc.line_resp_o), 256'(0));
  endtask

  initial begin
    int bad;
    int n;
    logic [3:0][63:0] d;
    rst = 1'b1;
    ifc.line_addr_i  = '0;
    ifc.line_read_i  = 1'b0;
    ifc.line_write_i = 1'b0;
    ifc.line_wdata_i = '0;
    ifc.mem_rdata_i  = '0;
    ifc.mem_resp_i   = 1'b0;
    #1;
    chk_outputs_zero("reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    mode = 0;
    do_txn(1, 0, 32'h8000_0024, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 5);
    do_txn(0, 1, 32'h0000_1040, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 5);
    mode = 1;
    do_txn(1, 0, 32'h1234_567F, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, -1);
    mode = 0;
    do_txn(1, 1, 32'h4000_0008, {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                                 64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001}, 5);

    // Reset in the middle of a fill: both queued expectations are discarded.
    d = {64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001};
    exp_q.push_back('{is_wr: 1'b0, addr: 32'h2000_0000, beats: d});
    for (int i = 0; i < 4; i++) rd_beats.push_back(d[i]);
    ifc.line_addr_i = 32'h2000_0010;
    ifc.line_read_i = 1'b1;
    n = 0;
    while (n < 50 && beat_n < 2) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(beat_n == 2, "mid_burst_timeout", 256'(beat_n), 256'(2));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("mid_burst_reset");
    exp_q.delete();
    rd_beats.delete();
    beat_n = 0;
    ifc.line_read_i = 1'b0;
    bad = 0;
    repeat (2) begin
      @(posedge clk);
      #2;
      if (ifc.line_resp_o) bad++;
    end
    chk(bad == 0, "resp_during_reset", 256'(bad), 256'(0));
    @(negedge clk) rst = 1'b0;

    spurious = 1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.line_resp_o || ifc.mem_read_o || ifc.mem_write_o) bad++;
    end
    chk(bad == 0, "spurious_idle", 256'(bad), 256'(0));
    spurious = 0;
    @(posedge clk);
    #1;
    do_txn(1, 0, 32'h2000_0010, {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                                 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001}, 5);

    for (int t = 0; t < 40; t++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      mode = $urandom_range(0, 2);
      a = $urandom;
      for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
      do_txn(k != 1, k != 0, a, d, (mode == 0) ? 5 : -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    chk(exp_q.size() == 0, "leftover_expect", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
